sysid_probe_ctrl: RTL and testbench
===================================

// Module: sysid_probe_ctrl
// PURPOSE
//  Avalon-MM read master that sequences a system-ID check against the sysid slave.
//  Reads the ID word (address 0), then the timestamp word (address 1), and compares both to expected values.
//  Reports pass or fail with an error code; retries on a stuck slave.
//  Sits beside the Nios II boot path, so firmware/hardware mismatch is flagged without CPU involvement.
// PARAMETERS
//  EXPECTED_ID     0           expected readdata at address 0
//  EXPECTED_TS     1539307324  expected readdata at address 1 (build timestamp)
//  TIMEOUT_CYCLES  255         max consecutive waitrequest-high cycles per read (>=1)
//  MAX_RETRIES     3           full-sequence retries after a timeout (0..15)
// PORTS
//  clock            in   1   single clock domain
//  reset            in   1   synchronous, active-high
//  start            in   1   pulse; begins a check when idle
//  avm_address      out  1   0 = ID word, 1 = timestamp word
//  avm_read         out  1   read request
//  avm_readdata     in   32  slave read data, valid when avm_read=1 and avm_waitrequest=0
//  avm_waitrequest  in   1   slave stall
//  busy             out  1   high from the cycle after start is accepted until done
//  done             out  1   one-cycle pulse at end of check
//  pass             out  1   1 = both words matched; held until the next start
//  err_code         out  2   0 ok, 1 ID mismatch, 2 TS mismatch, 3 timeout; held until the next start
//  id_value         out  32  captured ID word
//  ts_value         out  32  captured timestamp word
// BEHAVIOUR
//  Reset (sync, any state): state=IDLE, avm_read=0, avm_address=0, busy=0, done=0.
//   Also clears pass, err_code, id_value, ts_value, the retry count and the timeout count (all to 0).
//  States: IDLE, RD_ID, RD_TS, BACKOFF, CHECK.
//  IDLE: start=1 -> RD_ID on the next edge; clears pass/err_code and the retry count.
//   start while not IDLE is ignored.
//  RD_ID: avm_read=1, avm_address=0.
//   A read is accepted in the cycle avm_waitrequest=0; then id_value<=avm_readdata and -> RD_TS.
//  RD_TS: avm_read=1, avm_address=1.
//   On acceptance, ts_value<=avm_readdata and -> CHECK.
//   avm_read stays high across the RD_ID->RD_TS switch (back-to-back reads).
//  CHECK (1 cycle): done=1, -> IDLE.
//   ID mismatch -> err_code=1 (takes priority); else TS mismatch -> err_code=2; else err_code=0.
//   pass=(err_code==0). If entered via timeout, err_code=3 and pass=0.
//  Latency, zero wait states: start sampled at T0, RD_ID at T1, RD_TS at T2, done at T3.
//  Timeout: the counter is cleared on entry to RD_ID/RD_TS and increments each cycle waitrequest=1.
//   Expiry: counter==TIMEOUT_CYCLES with waitrequest still 1.
//   On expiry, if retries<MAX_RETRIES -> BACKOFF and retries+1; otherwise -> CHECK with err_code=3.
//   Counter width is clog2(TIMEOUT_CYCLES+1); the counter never wraps.
//  BACKOFF (1 cycle): avm_read=0, then -> RD_ID. The sequence restarts at address 0.
//  Acceptance in the same cycle the counter hits TIMEOUT_CYCLES counts as acceptance, not timeout.
//  Captured data on a failed attempt is overwritten by the retry.
//  busy = (state != IDLE); done is high only in CHECK.
// TESTING
//  1. Zero-wait slave returns 0 then 1539307324; start at T0 -> read addr0 at T1, addr1 at T2.
//     Expect done at T3, pass=1, err_code=0.
//  2. Slave returns 5 at addr0 -> pass=0, err_code=1, id_value=5 (ID mismatch wins even if TS also wrong).
//  3. Addr1 returns 0x12345678 -> err_code=2, ts_value=0x12345678.
//  4. waitrequest stuck high, TIMEOUT_CYCLES=4, MAX_RETRIES=1 -> two attempts with one BACKOFF cycle (read=0).
//     Expect done with err_code=3, pass=0.
//  5. 3 wait cycles on each read -> pass=1, done at T9; start pulses during busy are ignored.
//  6. Assert reset while in RD_TS -> next cycle avm_read=0, busy=0, all outputs at reset values.
//     A fresh start then yields pass=1.

Source files
------------

// File: rtl/sysid_probe_ctrl.sv
// rtl/sysid_probe_ctrl.sv - Avalon-MM read master that checks sysid ID/timestamp words
// Reads address 0 then 1, compares against expected values, retries whole sequence on slave timeout.
module sysid_probe_ctrl #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = 32'd1539307324,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          MAX_RETRIES    = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  err_code,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int             TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]     RMAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_RD_TS,
    S_BACKOFF,
    S_CHECK
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_tcnt;
  logic [3:0]    r_retries;
  logic          r_pass;
  logic [1:0]    r_err;
  logic [31:0]   r_id;
  logic [31:0]   r_ts;
  logic          w_accept;
  logic          w_expire;
  logic          w_retry;

  assign w_retry = (r_retries < RMAX);

  always_comb begin
    w_next      = r_state;
    avm_read    = 1'b0;
    avm_address = 1'b0;
    w_accept    = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_RD_ID;
      end
      S_RD_ID, S_RD_TS: begin
        avm_read    = 1'b1;
        avm_address = (r_state == S_RD_TS);
        if (!avm_waitrequest) begin
          // acceptance wins even when the counter has just reached its limit
          w_accept = 1'b1;
          w_next   = (r_state == S_RD_ID) ? S_RD_TS : S_CHECK;
        end else if (r_tcnt == TMAX) begin
          w_expire = 1'b1;
          w_next   = w_retry ? S_BACKOFF : S_CHECK;
        end
      end
      S_BACKOFF: w_next = S_RD_ID;
      S_CHECK:   w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_CHECK);
  assign pass     = r_pass;
  assign err_code = r_err;
  assign id_value = r_id;
  assign ts_value = r_ts;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_tcnt    <= '0;
      r_retries <= '0;
      r_pass    <= 1'b0;
      r_err     <= 2'd0;
      r_id      <= '0;
      r_ts      <= '0;
    end else begin
      r_state <= w_next;
      // counter restarts on every state change, saturates at the limit
      if (w_next != r_state) begin
        r_tcnt <= '0;
      end else if (avm_read && avm_waitrequest && (r_tcnt != TMAX)) begin
        r_tcnt <= r_tcnt + TW'(1);
      end

      if (r_state == S_IDLE && start) begin
        r_pass    <= 1'b0;
        r_err     <= 2'd0;
        r_retries <= '0;
      end

      if (w_accept && r_state == S_RD_ID) begin
        r_id <= avm_readdata;
      end

      if (w_accept && r_state == S_RD_TS) begin
        r_ts <= avm_readdata;
        if (r_id != EXPECTED_ID) begin
          r_err  <= 2'd1;
          r_pass <= 1'b0;
        end else if (avm_readdata != EXPECTED_TS) begin
          r_err  <= 2'd2;
          r_pass <= 1'b0;
        end else begin
          r_err  <= 2'd0;
          r_pass <= 1'b1;
        end
      end

      if (w_expire) begin
        if (w_retry) begin
          r_retries <= r_retries + 4'd1;
        end else begin
          r_err  <= 2'd3;
          r_pass <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sysid_probe_ctrl.sv
// tb/tb_sysid_probe_ctrl.sv - self-checking bench for sysid_probe_ctrl
module tb_sysid_probe_ctrl;

  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1539307324;
  localparam int          TO     = 4;
  localparam int          MR     = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  err_code;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  int vectors = 0;
  int errors  = 0;

  int done_cyc;
  int n_backoff;
  logic rd1, ad1, rd2, ad2;

  sysid_probe_ctrl #(
    .EXPECTED_ID(EXP_ID),
    .EXPECTED_TS(EXP_TS),
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRIES(MR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_code(err_code),
    .id_value(id_value),
    .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave model: stalls every read during the first stuck_att attempts, otherwise
  // inserts 'waits' wait states per read. Cycle 0 is the cycle start is sampled.
  task automatic run_check(input logic [31:0] idw, input logic [31:0] tsw,
                           input int waits, input int stuck_att, input bit noise);
    int   stall;
    int   att;
    logic prev_rd;
    logic prev_ad;
    stall = 0; att = 0; prev_rd = 1'b0; prev_ad = 1'b0;
    done_cyc = -1; n_backoff = 0;
    rd1 = 1'b0; ad1 = 1'b0; rd2 = 1'b0; ad2 = 1'b0;
    @(negedge clock);
    start = 1'b1;
    for (int cyc = 1; cyc < 200; cyc++) begin
      @(negedge clock);
      start = 1'b0;
      if (cyc == 1) begin rd1 = avm_read; ad1 = avm_address; end
      if (cyc == 2) begin rd2 = avm_read; ad2 = avm_address; end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (busy && !avm_read) n_backoff++;
      if (avm_read) begin
        if (!prev_rd || prev_ad != avm_address) begin
          stall = 0;
          if (avm_address == 1'b0) att++;
        end
        avm_readdata = avm_address ? tsw : idw;
        if (att <= stuck_att) begin
          avm_waitrequest = 1'b1;
        end else if (stall < waits) begin
          avm_waitrequest = 1'b1;
          stall++;
        end else begin
          avm_waitrequest = 1'b0;
        end
      end else begin
        avm_waitrequest = 1'($urandom_range(0, 1));
        avm_readdata    = $urandom;
      end
      prev_rd = avm_read;
      prev_ad = avm_address;
      if (noise && busy) start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
  endtask

  task automatic run_and_score(input string tag, input logic [31:0] idw, input logic [31:0] tsw,
                               input int waits, input int stuck_att, input bit noise);
    bit   timed_out;
    int   exp_done;
    int   exp_bo;
    logic [1:0] exp_err;
    timed_out = (stuck_att > MR);
    exp_done  = timed_out ? 1 + (MR + 1) * (TO + 1) + MR
                          : 1 + stuck_att * (TO + 2) + 2 * (waits + 1);
    exp_bo    = (stuck_att < MR) ? stuck_att : MR;
    if (timed_out)          exp_err = 2'd3;
    else if (idw != EXP_ID) exp_err = 2'd1;
    else if (tsw != EXP_TS) exp_err = 2'd2;
    else                    exp_err = 2'd0;

    run_check(idw, tsw, waits, stuck_att, noise);
    check({tag, ".done_cyc"}, 32'(done_cyc), 32'(exp_done));
    check({tag, ".backoff"},  32'(n_backoff), 32'(exp_bo));
    check({tag, ".err"},      32'(err_code), 32'(exp_err));
    check({tag, ".pass"},     32'(pass), 32'(exp_err == 2'd0));
    if (!timed_out) begin
      check({tag, ".id"}, id_value, idw);
      check({tag, ".ts"}, ts_value, tsw);
    end
    @(negedge clock);
    check({tag, ".done_low"}, 32'(done), 32'd0);
    check({tag, ".idle"},     32'(busy), 32'd0);
    check({tag, ".held"},     32'({pass, err_code}), 32'({exp_err == 2'd0, exp_err}));
  endtask

  initial begin
    logic [31:0] ridw;
    logic [31:0] rtsw;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.read", 32'(avm_read), 32'd0);
    check("rst.addr", 32'(avm_address), 32'd0);
    check("rst.pass", 32'(pass), 32'd0);
    check("rst.err",  32'(err_code), 32'd0);
    check("rst.id",   id_value, 32'd0);
    check("rst.ts",   ts_value, 32'd0);

    run_and_score("zero_wait", EXP_ID, EXP_TS, 0, 0, 1'b0);
    check("zw.rd1", 32'({rd1, ad1}), 32'b10);
    check("zw.rd2", 32'({rd2, ad2}), 32'b11);

    run_and_score("id_mis",    32'd5, 32'hDEAD_BEEF, 0, 0, 1'b0);
    run_and_score("ts_mis",    EXP_ID, 32'h1234_5678, 0, 0, 1'b0);
    run_and_score("timeout",   EXP_ID, EXP_TS, 0, 2, 1'b0);
    run_and_score("wait3",     EXP_ID, EXP_TS, 3, 0, 1'b1);
    run_and_score("wait_max",  EXP_ID, EXP_TS, TO, 0, 1'b0);
    run_and_score("retry_ok",  EXP_ID, EXP_TS, 1, 1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      ridw = $urandom_range(0, 1) ? EXP_ID : $urandom;
      rtsw = $urandom_range(0, 1) ? EXP_TS : $urandom;
      run_and_score($sformatf("rand%0d", i), ridw, rtsw,
                    $urandom_range(0, TO), $urandom_range(0, 2), 1'b1);
    end

    // reset while reading the timestamp word
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'd5;
    @(negedge clock);
    check("mid.rd_ts", 32'({avm_read, avm_address}), 32'b11);
    avm_waitrequest = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mid.read", 32'(avm_read), 32'd0);
    check("mid.busy", 32'(busy), 32'd0);
    check("mid.done", 32'(done), 32'd0);
    check("mid.pass", 32'(pass), 32'd0);
    check("mid.err",  32'(err_code), 32'd0);
    check("mid.id",   id_value, 32'd0);
    check("mid.ts",   ts_value, 32'd0);

    run_and_score("post_rst", EXP_ID, EXP_TS, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
